// File: rtl/led_frame_scanner.sv
// Double-buffered 8x8 RGB frame store scanned column by column onto the LED matrix.
// Optional LED_BRIGHTNESS_EN adds a 3-bit brightness input that trims the lit part of each dwell.
module led_frame_scanner #(
    parameter int DWELL_CYCLES = 10000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       Clear,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_col,
    input  logic [7:0] wr_r,
    input  logic [7:0] wr_g,
    input  logic [7:0] wr_b,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic [7:0] R_color,
    output logic [7:0] G_color,
    output logic [7:0] B_color,
    output logic [3:0] column,
    output logic       frame_tick
`ifdef LED_BRIGHTNESS_EN
    ,
    input  logic [2:0] brightness
`endif
);

    localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    col_q, col_d;

    logic [23:0]   bank_q [2][8];
    logic [23:0]   bank_d [2][8];
    logic          front_q, front_d;
    logic          pending_q, pending_d;
    logic [7:0]    r_q, r_d;
    logic [7:0]    g_q, g_d;
    logic [7:0]    b_q, b_d;

    logic          show_lit;
    logic [23:0]   pixel;

    // Scan FSM next state: BLANK guard, then SHOW dwell, then advance column
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        col_d   = col_q;
        unique case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    col_d   = col_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Scan FSM state register
    always_ff @(posedge CLK) begin
        if (Clear) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            col_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
        end
    end

    assign frame_tick = (state_q == ST_SHOW) && (cnt_q == DWELL_LAST) && (col_q == 3'd7);
    assign swap_ack   = frame_tick && pending_q && !Clear;
    assign wr_ready   = !pending_q;
    assign column     = {1'b1, col_q};
    assign R_color    = r_q;
    assign G_color    = g_q;
    assign B_color    = b_q;

`ifdef LED_BRIGHTNESS_EN
    logic [31:0] lit_len;
    // Lit portion of the dwell scales with brightness; 7 keeps the whole dwell
    always_comb begin
        lit_len  = ((32'(brightness) + 32'd1) * 32'(DWELL_CYCLES)) >> 3;
        show_lit = 32'(cnt_d) < lit_len;
    end
`else
    assign show_lit = 1'b1;
`endif

    assign pixel = bank_q[front_q][col_d];

    // Back-buffer writes, swap bookkeeping and registered active-low colour drive
    always_comb begin
        bank_d    = bank_q;
        front_d   = front_q;
        pending_d = pending_q;
        r_d       = 8'hFF;
        g_d       = 8'hFF;
        b_d       = 8'hFF;
        if (wr_valid && wr_ready) begin
            bank_d[!front_q][wr_col] = {wr_r, wr_g, wr_b};
        end
        if (swap_ack) begin
            front_d   = !front_q;
            pending_d = 1'b0;
        end else if (swap_req) begin
            pending_d = 1'b1;
        end
        if ((state_d == ST_SHOW) && show_lit) begin
            r_d = ~pixel[23:16];
            g_d = ~pixel[15:8];
            b_d = ~pixel[7:0];
        end
    end

    // Frame store and output registers
    always_ff @(posedge CLK) begin
        if (Clear) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 8; j++) begin
                    bank_q[i][j] <= '0;
                end
            end
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            r_q       <= 8'hFF;
            g_q       <= 8'hFF;
            b_q       <= 8'hFF;
        end else begin
            bank_q    <= bank_d;
            front_q   <= front_d;
            pending_q <= pending_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

endmodule

// File: tb/tb_led_frame_scanner.sv
// Scoreboard bench for led_frame_scanner: time-indexed reference model feeds
// an expectation queue, a negedge monitor compares every cycle.
module tb_led_frame_scanner;

    localparam int D = 4;
    localparam int B = 1;
    localparam int P = D + B;

    logic       CLK = 1'b0;
    logic       Clear = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_col = 3'd0;
    logic [7:0] wr_r = 8'h00;
    logic [7:0] wr_g = 8'h00;
    logic [7:0] wr_b = 8'h00;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic [7:0] R_color;
    logic [7:0] G_color;
    logic [7:0] B_color;
    logic [3:0] column;
    logic       frame_tick;

    led_frame_scanner #(
        .DWELL_CYCLES(D),
        .BLANK_CYCLES(B)
    ) dut (
        .CLK(CLK),
        .Clear(Clear),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_col(wr_col),
        .wr_r(wr_r),
        .wr_g(wr_g),
        .wr_b(wr_b),
        .swap_req(swap_req),
        .swap_ack(swap_ack),
        .R_color(R_color),
        .G_color(G_color),
        .B_color(B_color),
        .column(column),
        .frame_tick(frame_tick)
    );

    always #5 CLK = ~CLK;

    // Reference model: cycles since reset, two banks, front select, pending flag
    int          m_t;
    logic [23:0] m_bank [2][8];
    bit          m_front;
    bit          m_pending;

    logic [30:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_acks = 0;

    function automatic void model_reset();
        m_t = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 8; j++)
                m_bank[i][j] = 24'h0;
        m_front   = 1'b0;
        m_pending = 1'b0;
    endfunction

    function automatic int m_col();
        return (m_t / P) % 8;
    endfunction

    task automatic cyc(input bit c, input bit v, input logic [2:0] col,
                       input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input bit s);
        int          ph;
        int          mc;
        bit          show;
        bit          tick;
        bit          ack;
        logic [23:0] px;
        logic [23:0] rgb;
        @(posedge CLK);
        #1;
        Clear    = c;
        wr_valid = v;
        wr_col   = col;
        wr_r     = r;
        wr_g     = g;
        wr_b     = b;
        swap_req = s;
        ph   = m_t % P;
        mc   = m_col();
        show = (ph >= B);
        tick = show && (ph == P - 1) && (mc == 7);
        ack  = tick && m_pending && !c;
        px   = m_bank[m_front][mc];
        rgb  = show ? ~px : 24'hFFFFFF;
        exp_q.push_back({rgb, 1'b1, 3'(mc), !m_pending, ack, tick});
        if (c) begin
            model_reset();
        end else begin
            if (v && !m_pending)
                m_bank[!m_front][col] = {r, g, b};
            if (ack) begin
                m_front   = !m_front;
                m_pending = 1'b0;
            end else if (s) begin
                m_pending = 1'b1;
            end
            m_t++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic idle_to_col(input int c);
        for (int i = 0; i < 4 * P * 8 && m_col() != c; i++)
            idle(1);
    endtask

    // Monitor: pop and compare the expected output vector every cycle
    always @(negedge CLK) begin
        logic [30:0] e;
        logic [30:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {R_color, G_color, B_color, column, wr_ready, swap_ack, frame_tick};
            n_checks++;
            if (swap_ack)
                n_acks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t got R=%h G=%h B=%h col=%b rdy=%b ack=%b tick=%b exp R=%h G=%h B=%h col=%b rdy=%b ack=%b tick=%b",
                         $time, a[30:23], a[22:15], a[14:7], a[6:3], a[2], a[1], a[0],
                         e[30:23], e[22:15], e[14:7], e[6:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        int k;
        model_reset();
        @(posedge CLK);
        model_reset();
        // reset held two cycles
        cyc(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
        // empty scan, two frames
        idle(80);
        // write col 3 then swap
        cyc(1'b0, 1'b1, 3'd3, 8'h81, 8'h00, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(100);
        // write without swap
        cyc(1'b0, 1'b1, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        idle(80);
        // pending swap blocks writes
        idle_to_col(2);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        k = 0;
        while (m_pending && k < 100) begin
            cyc(1'b0, 1'b1, 3'd5, 8'h00, 8'h01, 8'h00, 1'b0);
            k++;
        end
        idle(10);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(90);
        // clear mid-frame with a swap pending
        idle_to_col(5);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(2);
        cyc(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(100);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(90);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(90);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(199) == 0, 1'($urandom),
                3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(29) == 0);
        end
        idle(5);
        @(negedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending expectations, need 0", exp_q.size());
        end
        n_checks++;
        if (n_acks == 0) begin
            n_fail++;
            $display("FAIL ack_seen got %0d swap acks, need at least 1", n_acks);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
